// File: rtl/d_latch_unit_if.sv
// Signal bundle for d_latch_unit: latch gate and data in, stored value and status out.
// The stimulus side uses master; the latch itself uses slave.
interface d_latch_unit_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic             E;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             Q_VALID;
  logic             CHG;
  logic [CNT_W-1:0] CAP_CNT;

  modport master (
    output E, D,
    input  Q, Q_VALID, CHG, CAP_CNT
  );

  modport slave (
    input  E, D,
    output Q, Q_VALID, CHG, CAP_CNT
  );
endinterface

// File: rtl/d_latch_unit.sv
// Clocked gated-D latch: captures D on every edge while E is high and holds it otherwise.
// It also reports whether the stored value is valid, whether a capture changed it, and a saturating capture count.
module d_latch_unit #(
  parameter int WIDTH       = 1,
  parameter int TRANSPARENT = 0,
  parameter int CNT_W       = 16
) (
  input  logic           CLK,
  input  logic           RST,
  d_latch_unit_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_chg;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_sat;
  logic             w_pass;

  assign w_cnt_sat = (r_cnt == CNT_MAX);
  assign w_pass    = bus.E & ~RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q     <= '0;
      r_valid <= 1'b0;
      r_chg   <= 1'b0;
      r_cnt   <= '0;
    end else if (bus.E) begin
      r_q     <= bus.D;
      r_valid <= 1'b1;
      r_chg   <= (bus.D != r_q);
      if (!w_cnt_sat) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else begin
      r_chg <= 1'b0;
    end
  end

  // The transparent variant bypasses the register so D reaches Q in the same cycle.
  generate
    if (TRANSPARENT != 0) begin : g_transparent
      assign bus.Q = w_pass ? bus.D : r_q;
    end else begin : g_registered
      assign bus.Q = r_q;
    end
  endgenerate

  assign bus.Q_VALID = r_valid;
  assign bus.CHG     = r_chg;
  assign bus.CAP_CNT = r_cnt;
endmodule

// File: tb/tb_d_latch_unit.sv
// Bench for d_latch_unit: a registered 1-bit unit, a transparent 8-bit unit and a 4-bit unit with a 4-bit counter.
// Expected outputs are queued when stimulus is driven and popped after the following clock edge.
module tb_d_latch_unit;
  logic CLK;
  logic RST;

  d_latch_unit_if #(.WIDTH(1), .CNT_W(16)) ifa ();
  d_latch_unit_if #(.WIDTH(8), .CNT_W(16)) ifb ();
  d_latch_unit_if #(.WIDTH(4), .CNT_W(4))  ifc ();

  d_latch_unit #(.WIDTH(1), .TRANSPARENT(0), .CNT_W(16)) u_a (.CLK(CLK), .RST(RST), .bus(ifa));
  d_latch_unit #(.WIDTH(8), .TRANSPARENT(1), .CNT_W(16)) u_b (.CLK(CLK), .RST(RST), .bus(ifb));
  d_latch_unit #(.WIDTH(4), .TRANSPARENT(0), .CNT_W(4))  u_c (.CLK(CLK), .RST(RST), .bus(ifc));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  q;
    logic        valid;
    logic        chg;
    logic [15:0] cnt;
  } obs_t;

  obs_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Bench-side copy of the inputs and reference state of each unit
  logic [7:0]  t_d   [3];
  logic        t_e   [3];
  logic [7:0]  m_q   [3];
  logic        m_val [3];
  logic        m_chg [3];
  logic [15:0] m_cnt [3];
  logic        t_rst;

  function automatic logic [7:0] dmask(input int k);
    return (k == 0) ? 8'h01 : (k == 1) ? 8'hFF : 8'h0F;
  endfunction

  function automatic logic [15:0] cmax(input int k);
    return (k == 2) ? 16'h000F : 16'hFFFF;
  endfunction

  function automatic obs_t observe(input int k);
    obs_t o;
    if (k == 0) o = '{q: {7'd0, ifa.Q}, valid: ifa.Q_VALID, chg: ifa.CHG, cnt: ifa.CAP_CNT};
    else if (k == 1) o = '{q: ifb.Q, valid: ifb.Q_VALID, chg: ifb.CHG, cnt: ifb.CAP_CNT};
    else o = '{q: {4'd0, ifc.Q}, valid: ifc.Q_VALID, chg: ifc.CHG, cnt: {12'd0, ifc.CAP_CNT}};
    return o;
  endfunction

  // Apply inputs for this cycle, advance every reference to the next edge, queue the expectation for unit sel
  task automatic drive(input int sel, input logic rst, input logic e, input logic [7:0] d);
    obs_t ex;
    t_rst    = rst;
    t_e[sel] = e;
    t_d[sel] = d & dmask(sel);
    RST      = t_rst;
    ifa.E = t_e[0]; ifa.D = t_d[0][0];
    ifb.E = t_e[1]; ifb.D = t_d[1];
    ifc.E = t_e[2]; ifc.D = t_d[2][3:0];
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_q[k] = 8'd0; m_val[k] = 1'b0; m_chg[k] = 1'b0; m_cnt[k] = 16'd0;
      end else if (t_e[k]) begin
        m_chg[k] = (t_d[k] != m_q[k]);
        m_q[k]   = t_d[k];
        m_val[k] = 1'b1;
        if (m_cnt[k] < cmax(k)) m_cnt[k] = m_cnt[k] + 16'd1;
      end else begin
        m_chg[k] = 1'b0;
      end
    end
    ex.q     = (sel == 1 && t_e[1] && !rst) ? t_d[1] : m_q[sel];
    ex.valid = m_val[sel];
    ex.chg   = m_chg[sel];
    ex.cnt   = m_cnt[sel];
    sb.push_back(ex);
  endtask

  task automatic test_reset();
    obs_t ex, ob;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b1, 1'b1, 8'h01);
      @(posedge CLK); #1;
      ex = sb.pop_front(); ob = observe(0); n_vec++;
      if (ob !== ex) begin
        n_err++;
        $display("FAIL reset[%0d]: got q=%h v=%b c=%b n=%0d, want q=%h v=%b c=%b n=%0d",
                 i, ob.q, ob.valid, ob.chg, ob.cnt, ex.q, ex.valid, ex.chg, ex.cnt);
      end
    end
  endtask

  task automatic test_capture_hold();
    obs_t ex, ob;
    for (int i = 0; i < 8; i++) begin
      // One capture of 1, five holds with D toggling, then two captures of an equal value
      if (i == 0) drive(0, 1'b0, 1'b1, 8'h01);
      else if (i < 6) drive(0, 1'b0, 1'b0, (i % 2 == 1) ? 8'h00 : 8'h01);
      else drive(0, 1'b0, 1'b1, 8'h01);
      @(posedge CLK); #1;
      ex = sb.pop_front(); ob = observe(0); n_vec++;
      if (ob !== ex) begin
        n_err++;
        $display("FAIL capture_hold[%0d]: got q=%h v=%b c=%b n=%0d, want q=%h v=%b c=%b n=%0d",
                 i, ob.q, ob.valid, ob.chg, ob.cnt, ex.q, ex.valid, ex.chg, ex.cnt);
      end
    end
  endtask

  task automatic test_free_run();
    obs_t ex, ob;
    int   n_cap = 0;
    int   n_bad = 0;
    drive(0, 1'b1, 1'b0, 8'h00);
    @(posedge CLK); #1;
    void'(sb.pop_front());
    for (int c = 0; c < 1000; c++) begin
      logic e_v, d_v;
      e_v = ((c / 3) % 2) == 1;
      d_v = ((c / 5) % 2) == 1;
      if (e_v) n_cap++;
      drive(0, 1'b0, e_v, {7'd0, d_v});
      @(posedge CLK); #1;
      ex = sb.pop_front(); ob = observe(0); n_vec++;
      if (ob !== ex) begin
        n_err++;
        if (n_bad++ < 5)
          $display("FAIL free_run[%0d]: got q=%h v=%b c=%b n=%0d, want q=%h v=%b c=%b n=%0d",
                   c, ob.q, ob.valid, ob.chg, ob.cnt, ex.q, ex.valid, ex.chg, ex.cnt);
      end
    end
    n_vec++;
    if (ifa.CAP_CNT !== 16'(n_cap)) begin
      n_err++;
      $display("FAIL free_run_count: got %0d, want %0d", ifa.CAP_CNT, n_cap);
    end
  endtask

  task automatic test_transparent();
    obs_t ex, ob;
    drive(1, 1'b1, 1'b0, 8'h00);
    @(posedge CLK); #1;
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive(1, 1'b0, 1'b1, 8'hA5);
        1: drive(1, 1'b0, 1'b0, 8'h3C);
        2: drive(1, 1'b0, 1'b1, 8'h3C);
        default: drive(1, 1'b0, 1'b1, 8'h3C);
      endcase
      #1;
      n_vec++;
      if (ifb.Q !== ((i == 1) ? 8'hA5 : 8'h3C) && !(i == 0 && ifb.Q === 8'hA5)) begin
        n_err++;
        $display("FAIL transparent_comb[%0d]: got %h, want %h", i, ifb.Q,
                 (i == 1 || i == 0) ? 8'hA5 : 8'h3C);
      end
      @(posedge CLK); #1;
      ex = sb.pop_front(); ob = observe(1); n_vec++;
      if (ob !== ex) begin
        n_err++;
        $display("FAIL transparent[%0d]: got q=%h v=%b c=%b n=%0d, want q=%h v=%b c=%b n=%0d",
                 i, ob.q, ob.valid, ob.chg, ob.cnt, ex.q, ex.valid, ex.chg, ex.cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t ex, ob;
    for (int i = 0; i < 9; i++) begin
      drive(2, (i == 4), 1'b1, 8'(i * 3 + 5));
      @(posedge CLK); #1;
      ex = sb.pop_front(); ob = observe(2); n_vec++;
      if (ob !== ex) begin
        n_err++;
        $display("FAIL reset_mid[%0d]: got q=%h v=%b c=%b n=%0d, want q=%h v=%b c=%b n=%0d",
                 i, ob.q, ob.valid, ob.chg, ob.cnt, ex.q, ex.valid, ex.chg, ex.cnt);
      end
    end
  endtask

  task automatic test_saturation();
    obs_t ex, ob;
    drive(2, 1'b1, 1'b0, 8'h00);
    @(posedge CLK); #1;
    void'(sb.pop_front());
    for (int i = 0; i < 20; i++) begin
      drive(2, 1'b0, 1'b1, 8'($urandom_range(0, 15)));
      @(posedge CLK); #1;
      ex = sb.pop_front(); ob = observe(2); n_vec++;
      if (ob !== ex) begin
        n_err++;
        $display("FAIL saturation[%0d]: got q=%h v=%b c=%b n=%0d, want q=%h v=%b c=%b n=%0d",
                 i, ob.q, ob.valid, ob.chg, ob.cnt, ex.q, ex.valid, ex.chg, ex.cnt);
      end
    end
    n_vec++;
    if (ifc.CAP_CNT !== 4'hF) begin
      n_err++;
      $display("FAIL saturation_final: got %0d, want 15", ifc.CAP_CNT);
    end
  endtask

  initial begin
    t_rst = 1'b1;
    RST   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t_e[k] = 1'b0; t_d[k] = 8'd0;
      m_q[k] = 8'd0; m_val[k] = 1'b0; m_chg[k] = 1'b0; m_cnt[k] = 16'd0;
    end
    ifa.E = 1'b0; ifa.D = 1'b0;
    ifb.E = 1'b0; ifb.D = 8'd0;
    ifc.E = 1'b0; ifc.D = 4'd0;
    @(posedge CLK); #1;
    test_reset();
    test_capture_hold();
    test_free_run();
    test_transparent();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/d_latch_unit.md
# d_latch_unit

Clock-synchronous emulation of a gated D latch with a synchronous active-high reset. While enable `E` is high the data input `D` is captured on every `CLK` edge. While `E` is low the stored value is held. An optional transparent output mode gives true latch-like pass-through. Status outputs report capture activity. The block is a drop-in storage/hold element for FPGA datapaths that must avoid inferred asynchronous latches.

## Interface
Parameters:
- `WIDTH`, default 1: data width of `D` and `Q`.
- `TRANSPARENT`, default 0:
  - 0: `Q` is the registered stored value.
  - 1: `Q` passes `D` combinationally while `E`=1 and `RST`=0.
- `CNT_W`, default 16: width of the capture counter.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `E` in 1: enable (latch gate); high = capture/transparent, low = hold.
- `D` in WIDTH: data input.
- `Q` in… out WIDTH: latch output.
- `Q_VALID` out 1: high once at least one capture has occurred since reset.
- `CHG` out 1: one-cycle pulse when a capture changed the stored value.
- `CAP_CNT` out CNT_W: number of capture cycles since reset, saturating.

## Operation
Internal state: `q_reg[WIDTH]`, `valid_reg`, `chg_reg`, `cnt_reg[CNT_W]`.

Each rising `CLK` edge:
- If `RST`=1: `q_reg`=0, `valid_reg`=0, `chg_reg`=0, `cnt_reg`=0. `RST` has priority over `E`.
- Else if `E`=1 (capture):
  - `q_reg` <= `D`.
  - `valid_reg` <= 1.
  - `chg_reg` <= (`D` != `q_reg`).
  - `cnt_reg` <= `cnt_reg`+1, saturating at all-ones.
- Else (hold): `q_reg`, `valid_reg` and `cnt_reg` unchanged; `chg_reg` <= 0.

Output `Q`:
- `TRANSPARENT`=0: `Q` = `q_reg`.
- `TRANSPARENT`=1: `Q` = (`E` & ~`RST`) ? `D` : `q_reg`. Pure combinational mux, with no extra register on the path.

Other outputs:
- `Q_VALID` = `valid_reg`; `CHG` = `chg_reg`; `CAP_CNT` = `cnt_reg`.
- No X propagation: all state is defined after the first reset edge.

Boundary cases:
- `E` and `D` changing in the same cycle: the value of `D` present at the edge is captured when `E` is high at that edge.
- `E` high for a single cycle: exactly one capture, and `CAP_CNT` increments by 1.
- Counter at all-ones: stays at all-ones; `Q` capture is unaffected.
- Reset asserted mid-hold or mid-capture: all state cleared at that edge. The first capture after reset deassertion sets `Q_VALID`.
- Capture of a value equal to `q_reg`: `CHG`=0, `CAP_CNT` still increments.

## Timing
- Reset values (registered outputs): `Q`=0, `Q_VALID`=0, `CHG`=0, `CAP_CNT`=0, all visible one cycle after the reset edge.
- `TRANSPARENT`=0: `D` to `Q` latency is 1 cycle (edge where `E`=1). `E` going low freezes `Q` at the last captured value.
- `TRANSPARENT`=1: `D` to `Q` is combinational (0 cycles) while `E`=1. When `E` falls, `Q` shows the value captured at the last edge with `E`=1.
- `CHG` and `CAP_CNT` update at the capture edge and are valid in the following cycle.
- No handshake; `E` and `D` are sampled every cycle.
- Inputs are synchronous to `CLK`; there is no internal synchronizer.

## Test plan
- Reset: hold `RST`=1 for 2 cycles with `E`=1, `D`=1 → `Q`=0, `Q_VALID`=0, `CAP_CNT`=0.
- Capture/hold (`TRANSPARENT`=0):
  - `E`=1, `D`=1 for 1 cycle → next cycle `Q`=1, `Q_VALID`=1, `CHG`=1, `CAP_CNT`=1.
  - Then `E`=0 and toggle `D` for 5 cycles → `Q` stays 1, `CHG`=0, `CAP_CNT`=1.
- Free-running stimulus: `E` toggles every 3 cycles and `D` every 5 cycles, for 1000 cycles.
  - `Q` must match a reference model every cycle.
  - `CAP_CNT` must equal the number of edges with `E`=1.
- Transparent mode (`TRANSPARENT`=1, `WIDTH`=8):
  - `E`=1, `D`=0xA5 → `Q`=0xA5 in the same cycle.
  - Drop `E` at the next edge, then set `D`=0x3C → `Q` stays 0xA5.
- Reset mid-operation: `E`=1 streaming values, assert `RST` for 1 cycle → `Q`=0 and `CAP_CNT`=0 next cycle. Capture resumes the cycle after release.
- Saturation (`CNT_W`=4): hold `E`=1 for 20 cycles → `CAP_CNT`=15 and stays 15; `Q` still tracks `D` with 1-cycle latency.
